// File: rtl/pwm_pkg.sv
// Shared constants and FSM phase encoding for the breathing controller and PWM stage.
package pwm_pkg;

    localparam int unsigned CNT_W_DEF        = 20;
    localparam int unsigned DUTY_MAX_DEF     = 1_000_000;
    localparam int unsigned STEP_DEF         = 10_000;
    localparam int unsigned HOLD_PERIODS_DEF = 50;
    localparam int unsigned PHASE_W          = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE    = 3'd0,
        PH_UP      = 3'd1,
        PH_HOLD_HI = 3'd2,
        PH_DOWN    = 3'd3,
        PH_HOLD_LO = 3'd4
    } phase_e;

endpackage

// File: rtl/pwm_breath_ctrl.sv
// Breathing duty ramp: ramps duty up, dwells at full scale, ramps down, dwells at zero.
// Every change lands only on a downstream period wrap so the PWM never sees a mid-period update.
module pwm_breath_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DUTY_MAX     = DUTY_MAX_DEF,
    parameter int unsigned STEP         = STEP_DEF,
    parameter int unsigned HOLD_PERIODS = HOLD_PERIODS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               period_done,
    output logic [CNT_W-1:0]   duty,
    output logic               duty_upd,
    output logic [PHASE_W-1:0] phase
);

    // One guard bit so duty+STEP can never wrap before saturation.
    localparam int unsigned EXT_W  = CNT_W + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_PERIODS + 1);

    localparam logic [EXT_W-1:0]  DMAX_X    = EXT_W'(DUTY_MAX);
    localparam logic [EXT_W-1:0]  STEP_X    = EXT_W'(STEP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_PERIODS);

    phase_e              state_q, state_d;
    logic [CNT_W-1:0]    duty_q, duty_d;
    logic                upd_q, upd_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [EXT_W-1:0]    duty_x;
    logic [EXT_W-1:0]    sum_x;
    logic [HOLD_W-1:0]   hold_inc;

    // Widened duty, saturating sum and saturating hold increment.
    always_comb begin
        duty_x   = {1'b0, duty_q};
        sum_x    = duty_x + STEP_X;
        hold_inc = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
    end

    // Next-state, next-duty and update-pulse logic; everything gated by period_done.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        upd_d   = 1'b0;

        if (period_done) begin
            if (!en) begin
                state_d = PH_IDLE;
                duty_d  = '0;
                hold_d  = '0;
            end else begin
                case (state_q)
                    PH_IDLE: begin
                        state_d = PH_UP;
                    end
                    PH_UP: begin
                        if (sum_x >= DMAX_X) begin
                            duty_d  = CNT_W'(DMAX_X);
                            state_d = PH_HOLD_HI;
                            hold_d  = '0;
                        end else begin
                            duty_d  = CNT_W'(sum_x);
                        end
                    end
                    PH_HOLD_HI, PH_HOLD_LO: begin
                        hold_d = hold_inc;
                        if (hold_q == HOLD_LAST) begin
                            state_d = (state_q == PH_HOLD_HI) ? PH_DOWN : PH_UP;
                            hold_d  = '0;
                        end
                    end
                    PH_DOWN: begin
                        if (duty_x <= STEP_X) begin
                            duty_d  = '0;
                            state_d = PH_HOLD_LO;
                            hold_d  = '0;
                        end else begin
                            // duty_q > STEP here, so STEP fits in CNT_W bits.
                            duty_d  = duty_q - CNT_W'(STEP_X);
                        end
                    end
                    default: begin
                        state_d = PH_IDLE;
                        duty_d  = '0;
                        hold_d  = '0;
                    end
                endcase
            end
            upd_d = (duty_d != duty_q);
        end
    end

    // State, duty, hold counter and update pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PH_IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            upd_q   <= upd_d;
        end
    end

    assign duty     = duty_q;
    assign duty_upd = upd_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Bench for pwm_breath_ctrl: two instances (STEP=4 and STEP=15) share one stimulus stream
// and are checked against a rule-level reference model.
module tb_pwm_breath_ctrl;
    import pwm_pkg::*;

    localparam int unsigned CW   = 8;
    localparam int unsigned DMAX = 10;
    localparam int unsigned HOLD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          pd;
    logic [CW-1:0] duty0, duty1;
    logic          upd0, upd1;
    logic [2:0]    ph0, ph1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance.
    int m_st  [2];
    int m_d   [2];
    int m_h   [2];
    int m_upd [2];

    int tbl_d  [12] = '{0, 4, 8, 10, 10, 10, 6, 2, 0, 0, 0, 4};
    int tbl_ph [12] = '{PH_IDLE, PH_UP, PH_UP, PH_UP, PH_HOLD_HI, PH_HOLD_HI,
                        PH_DOWN, PH_DOWN, PH_DOWN, PH_HOLD_LO, PH_HOLD_LO, PH_UP};

    pwm_breath_ctrl #(.CNT_W(CW), .DUTY_MAX(DMAX), .STEP(4), .HOLD_PERIODS(HOLD)) u_dut_s4 (
        .clk(clk), .rst(rst), .en(en), .period_done(pd),
        .duty(duty0), .duty_upd(upd0), .phase(ph0)
    );

    pwm_breath_ctrl #(.CNT_W(CW), .DUTY_MAX(DMAX), .STEP(15), .HOLD_PERIODS(HOLD)) u_dut_s15 (
        .clk(clk), .rst(rst), .en(en), .period_done(pd),
        .duty(duty1), .duty_upd(upd1), .phase(ph1)
    );

    always #5 clk = ~clk;

    function automatic int step_of(input int i);
        return (i == 0) ? 4 : 15;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i]  = PH_IDLE;
            m_d[i]   = 0;
            m_h[i]   = 0;
            m_upd[i] = 0;
        end
    endtask

    // One period_done worth of behaviour, straight from the ramp/dwell rules.
    task automatic model_step(input bit en_v);
        int prev;
        int stp;
        for (int i = 0; i < 2; i++) begin
            prev = m_d[i];
            stp  = step_of(i);
            if (!en_v) begin
                m_st[i] = PH_IDLE;
                m_d[i]  = 0;
                m_h[i]  = 0;
            end else if (m_st[i] == PH_IDLE) begin
                m_st[i] = PH_UP;
            end else if (m_st[i] == PH_UP) begin
                m_d[i] = (m_d[i] + stp > int'(DMAX)) ? int'(DMAX) : m_d[i] + stp;
                if (m_d[i] == int'(DMAX)) begin
                    m_st[i] = PH_HOLD_HI;
                    m_h[i]  = 0;
                end
            end else if (m_st[i] == PH_DOWN) begin
                m_d[i] = (m_d[i] < stp) ? 0 : m_d[i] - stp;
                if (m_d[i] == 0) begin
                    m_st[i] = PH_HOLD_LO;
                    m_h[i]  = 0;
                end
            end else begin
                m_h[i]++;
                if (m_h[i] >= int'(HOLD)) begin
                    m_st[i] = (m_st[i] == PH_HOLD_HI) ? PH_DOWN : PH_UP;
                    m_h[i]  = 0;
                end
            end
            m_upd[i] = (m_d[i] != prev) ? 1 : 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_duty0"}, 32'(duty0), 32'(m_d[0]));
        check({tag, "_ph0"},   32'(ph0),   32'(m_st[0]));
        check({tag, "_upd0"},  32'(upd0),  32'(m_upd[0]));
        check({tag, "_duty1"}, 32'(duty1), 32'(m_d[1]));
        check({tag, "_ph1"},   32'(ph1),   32'(m_st[1]));
        check({tag, "_upd1"},  32'(upd1),  32'(m_upd[1]));
    endtask

    // Drive one clock cycle at the falling edge, check just after the rising edge.
    task automatic cyc(input bit pd_v, input bit en_v, input string tag);
        @(negedge clk);
        pd = pd_v;
        en = en_v;
        @(posedge clk);
        if (pd_v) model_step(en_v);
        else begin
            m_upd[0] = 0;
            m_upd[1] = 0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'($urandom % 2), "gap");
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        pd = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] keep_d;
        logic [2:0]    keep_ph;

        rst = 1'b1;
        en  = 1'b0;
        pd  = 1'b0;
        model_reset();
        #1;
        check_all("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full breathing cycle with random en wiggle between period_done pulses.
        for (int k = 0; k < 12; k++) begin
            idle_gap(int'($urandom_range(0, 3)));
            check("seq_phase_before", 32'(ph0), 32'(tbl_ph[k]));
            cyc(1'b1, 1'b1, "seq");
            check("seq_duty", 32'(duty0), 32'(tbl_d[k]));
            if (k == 0) check("s15_first_duty", 32'(duty1), 32'd0);
            if (k == 1) begin
                check("s15_sat_duty", 32'(duty1), 32'd10);
                check("s15_sat_phase", 32'(ph1), 32'(PH_HOLD_HI));
            end
        end

        // Disable mid-ramp at duty 8.
        do_reset("rst1");
        repeat (3) cyc(1'b1, 1'b1, "ramp");
        check("dis_pre_duty", 32'(duty0), 32'd8);
        cyc(1'b1, 1'b0, "dis");
        check("dis_duty", 32'(duty0), 32'd0);
        check("dis_phase", 32'(ph0), 32'(PH_IDLE));
        check("dis_upd", 32'(upd0), 32'd1);
        cyc(1'b0, 1'b0, "dis_after");
        check("dis_upd_single", 32'(upd0), 32'd0);
        repeat (3) cyc(1'b1, 1'b0, "dis_hold");

        // Async reset while ramping down at duty 6, then restart from IDLE.
        do_reset("rst2");
        repeat (7) cyc(1'b1, 1'b1, "to_down");
        check("down_pre_duty", 32'(duty0), 32'd6);
        check("down_pre_phase", 32'(ph0), 32'(PH_DOWN));
        do_reset("rst_down");
        cyc(1'b1, 1'b1, "restart");
        check("restart_phase", 32'(ph0), 32'(PH_UP));
        check("restart_upd", 32'(upd0), 32'd0);

        // 100 cycles without period_done while en toggles: nothing moves.
        cyc(1'b1, 1'b1, "pre_quiet");
        keep_d  = duty0;
        keep_ph = ph0;
        for (int k = 0; k < 100; k++) cyc(1'b0, 1'($urandom % 2), "quiet");
        check("quiet_duty", 32'(duty0), 32'(keep_d));
        check("quiet_phase", 32'(ph0), 32'(keep_ph));

        // en=0 on the period_done that would end HOLD_HI.
        do_reset("rst3");
        repeat (5) cyc(1'b1, 1'b1, "to_hold");
        check("hold_pre_phase", 32'(ph0), 32'(PH_HOLD_HI));
        cyc(1'b1, 1'b0, "hold_exit");
        check("hold_exit_phase", 32'(ph0), 32'(PH_IDLE));
        check("hold_exit_duty", 32'(duty0), 32'd0);

        // Random traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            if ($urandom % 150 == 0) do_reset("rnd_rst");
            cyc(1'($urandom % 3 == 0), 1'($urandom % 8 != 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
